// File: rtl/xbar_cfg_loader_if.sv
// Configuration load channel: start strobe plus a valid/ready word stream.
// The master side drives the words; the slave side is the loader.
interface xbar_cfg_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic              io_cfg_start;
    logic              io_cfg_valid;
    logic              io_cfg_ready;
    logic [WORD_W-1:0] io_cfg_data;

    modport master (
        output io_cfg_start,
        output io_cfg_valid,
        output io_cfg_data,
        input  io_cfg_ready
    );

    modport slave (
        input  io_cfg_start,
        input  io_cfg_valid,
        input  io_cfg_data,
        output io_cfg_ready
    );
endinterface

// File: rtl/xbar_cfg_loader.sv
// Streams a crossbar select configuration into a shadow register, range-checks every field
// and commits it atomically onto io_mux_configs only when every field is legal.
module xbar_cfg_loader #(
    parameter int unsigned NUM_IN  = 18,
    parameter int unsigned NUM_OUT = 20,
    parameter int unsigned SEL_W   = 5,
    parameter int unsigned WORD_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    xbar_cfg_loader_if.slave           io_cfg,
    output logic [NUM_OUT*SEL_W-1:0]   io_mux_configs,
    output logic                       io_cfg_busy,
    output logic                       io_cfg_done,
    output logic                       io_cfg_error,
    output logic [$clog2(NUM_OUT)-1:0] io_cfg_err_idx
);
    localparam int unsigned CFG_W     = NUM_OUT * SEL_W;
    localparam int unsigned NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;
    localparam int unsigned IDX_W     = $clog2(NUM_OUT);
    localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_FIELD = IDX_W'(NUM_OUT - 1);
    localparam logic [SEL_W:0]   SEL_LIMIT  = (SEL_W + 1)'(NUM_IN);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck, StCommit} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [IDX_W-1:0]   r_field_idx;
    logic [CFG_W-1:0]   r_shadow;
    logic [CFG_W-1:0]   w_shadow_next;
    logic [CFG_W-1:0]   r_mux_configs;
    logic               r_done;
    logic               r_error;
    logic [IDX_W-1:0]   r_err_idx;
    logic [SEL_W-1:0]   w_field;

    logic               w_ready;
    logic               w_accept;
    logic               w_restart;
    logic               w_field_bad;
    logic               w_commit_go;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (io_cfg.io_cfg_start) w_state_next = StLoad;
            end
            StLoad: begin
                if (io_cfg.io_cfg_start) begin
                    w_state_next = StLoad;
                end else if (w_accept && (r_word_cnt == LAST_WORD)) begin
                    w_state_next = StCheck;
                end
            end
            StCheck: begin
                if (io_cfg.io_cfg_start) begin
                    w_state_next = StLoad;
                end else if (w_field_bad) begin
                    w_state_next = StIdle;
                end else if (w_commit_go) begin
                    w_state_next = StCommit;
                end
            end
            StCommit: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Output / control strobes
    always_comb begin
        w_ready     = (r_state == StLoad) && !io_cfg.io_cfg_start;
        w_accept    = w_ready && io_cfg.io_cfg_valid;
        // A start seen during COMMIT is ignored; the commit always completes.
        w_restart   = io_cfg.io_cfg_start && (r_state != StCommit);
        w_field_bad = (r_state == StCheck) && !io_cfg.io_cfg_start
                      && ({1'b0, w_field} >= SEL_LIMIT);
        w_commit_go = (r_state == StCheck) && !io_cfg.io_cfg_start && !w_field_bad
                      && (r_field_idx == LAST_FIELD);
    end

    // Field currently under examination
    always_comb begin
        w_field = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (r_field_idx == IDX_W'(i)) w_field = r_shadow[i*SEL_W +: SEL_W];
        end
    end

    // Word k lands at bit k*WORD_W; bits of the last word beyond CFG_W have no home.
    always_comb begin
        w_shadow_next = r_shadow;
        for (int unsigned i = 0; i < CFG_W; i++) begin
            if (r_word_cnt == CNT_W'(i / WORD_W)) begin
                w_shadow_next[i] = io_cfg.io_cfg_data[i % WORD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word_cnt    <= '0;
            r_field_idx   <= '0;
            r_shadow      <= '0;
            r_mux_configs <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_err_idx     <= '0;
        end else begin
            r_done <= w_commit_go;
            if (w_commit_go) r_mux_configs <= r_shadow;
            if (w_restart) begin
                r_word_cnt  <= '0;
                r_field_idx <= '0;
                r_shadow    <= '0;
                r_error     <= 1'b0;
                r_err_idx   <= '0;
            end else begin
                if (w_accept) begin
                    r_shadow   <= w_shadow_next;
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                end
                if (r_state == StCheck) r_field_idx <= r_field_idx + IDX_W'(1);
                if (w_field_bad) begin
                    r_error   <= 1'b1;
                    r_err_idx <= r_field_idx;
                end
            end
        end
    end

    assign io_cfg.io_cfg_ready = w_ready;
    assign io_cfg_busy         = (r_state != StIdle);
    assign io_cfg_done         = r_done;
    assign io_cfg_error        = r_error;
    assign io_cfg_err_idx      = r_err_idx;
    assign io_mux_configs      = r_mux_configs;
endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Directed bench for xbar_cfg_loader: reset, legal/illegal loads, backpressure, abort and
// reset during the field check, with cycle-exact latency checks.
module tb_xbar_cfg_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [99:0] mux;
    logic        done;
    logic        busy;
    logic        error;
    logic [4:0]  err_idx;

    int n_cmp = 0;
    int n_fail = 0;
    int ready_viol = 0;

    always #5 clk = ~clk;

    xbar_cfg_loader_if #(.WORD_W(8)) u_if ();

    xbar_cfg_loader #(
        .NUM_IN (18),
        .NUM_OUT(20),
        .SEL_W  (5),
        .WORD_W (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_cfg        (u_if),
        .io_mux_configs(mux),
        .io_cfg_busy   (busy),
        .io_cfg_done   (done),
        .io_cfg_error  (error),
        .io_cfg_err_idx(err_idx)
    );

    task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fields 0..17 = index, 18/19 = 17; one field optionally overridden. Pad bits set to 1.
    function automatic logic [103:0] mk_ramp(input int bad_idx, input int bad_val);
        logic [103:0] c;
        c = '0;
        c[103:100] = 4'hF;
        for (int i = 0; i < 20; i++) begin
            c[i*5 +: 5] = (i == bad_idx) ? 5'(bad_val) : ((i < 18) ? 5'(i) : 5'd17);
        end
        return c;
    endfunction

    function automatic logic [103:0] mk_fill(input int v);
        logic [103:0] c;
        c = '0;
        c[103:100] = 4'hA;
        for (int i = 0; i < 20; i++) c[i*5 +: 5] = 5'(v);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start from a post-edge point; checks the s+1 ready/busy and ends post-edge.
    task automatic do_start();
        u_if.io_cfg_start = 1'b1;
        step();
        u_if.io_cfg_start = 1'b0;
        @(negedge clk);
        chk("start_ready", u_if.io_cfg_ready, 1);
        chk("start_busy", busy, 1);
        step();
    endtask

    // Presents up to nmax words; with gaps, valid follows 1,0,0,1,0,0...
    task automatic send_cfg(input logic [103:0] w, input bit gaps, input int nmax,
                            output int n_acc);
        int  k = 0;
        int  t = 0;
        bit  acc;
        while (k < nmax && t < 200) begin
            u_if.io_cfg_valid = gaps ? (t % 3 == 0) : 1'b1;
            u_if.io_cfg_data  = w[k*8 +: 8];
            @(negedge clk);
            acc = u_if.io_cfg_valid && u_if.io_cfg_ready;
            step();
            if (acc) k++;
            t++;
        end
        u_if.io_cfg_valid = 1'b0;
        u_if.io_cfg_data  = '0;
        n_acc = k;
    endtask

    // Caller sits at the negedge of cycle a+1; returns at the negedge of cycle a+off.
    task automatic wait_result(output int off);
        off = 1;
        while (!(done || error) && off < 40) begin
            if (u_if.io_cfg_ready) ready_viol++;
            step();
            @(negedge clk);
            off++;
        end
    endtask

    initial begin
        logic [103:0] cfg_a;
        logic [103:0] cfg_b;
        int           n;
        int           off;
        int           n_done;

        cfg_a = mk_ramp(-1, 0);
        cfg_b = mk_fill(9);
        u_if.io_cfg_start = 1'b0;
        u_if.io_cfg_valid = 1'b0;
        u_if.io_cfg_data  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mux", mux, 0);
        chk("rst_ready", u_if.io_cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_idx", err_idx, 0);

        // Valid while idle is ignored
        step();
        u_if.io_cfg_valid = 1'b1;
        u_if.io_cfg_data  = 8'h55;
        @(negedge clk);
        chk("idle_ready", u_if.io_cfg_ready, 0);
        chk("idle_busy", busy, 0);
        step();
        u_if.io_cfg_valid = 1'b0;

        // Legal back-to-back load
        do_start();
        send_cfg(cfg_a, 1'b0, 13, n);
        chk("legal_n", n, 13);
        @(negedge clk);
        chk("legal_check_ready", u_if.io_cfg_ready, 0);
        chk("legal_check_busy", busy, 1);
        wait_result(off);
        chk("legal_latency", off, 21);
        chk("legal_done", done, 1);
        chk("legal_mux", mux, {4'h0, cfg_a[99:0]});
        chk("legal_f0", mux[4:0], 0);
        chk("legal_f17", mux[89:85], 17);
        chk("legal_f19", mux[99:95], 17);
        chk("legal_error", error, 0);
        step();
        @(negedge clk);
        chk("legal_done_pulse", done, 0);
        chk("legal_busy_end", busy, 0);
        step();

        // Field 7 illegal
        do_start();
        send_cfg(mk_ramp(7, 25), 1'b0, 13, n);
        chk("illegal_n", n, 13);
        @(negedge clk);
        wait_result(off);
        chk("illegal_latency", off, 9);
        chk("illegal_error", error, 1);
        chk("illegal_err_idx", err_idx, 7);
        chk("illegal_busy", busy, 0);
        chk("illegal_done", done, 0);
        chk("illegal_mux_kept", mux, {4'h0, cfg_a[99:0]});
        repeat (3) step();
        @(negedge clk);
        chk("illegal_sticky", error, 1);
        chk("illegal_no_done", done, 0);
        step();

        // Error holds through the start cycle and clears the cycle after
        u_if.io_cfg_start = 1'b1;
        @(negedge clk);
        chk("errclr_s_error", error, 1);
        step();
        u_if.io_cfg_start = 1'b0;
        @(negedge clk);
        chk("errclr_error", error, 0);
        chk("errclr_err_idx", err_idx, 0);
        chk("errclr_ready", u_if.io_cfg_ready, 1);
        step();

        // Abort after 6 words, with a word offered in the start cycle
        send_cfg(mk_fill(3), 1'b0, 6, n);
        chk("abort_n6", n, 6);
        u_if.io_cfg_start = 1'b1;
        u_if.io_cfg_valid = 1'b1;
        u_if.io_cfg_data  = 8'hFF;
        @(negedge clk);
        chk("abort_ready", u_if.io_cfg_ready, 0);
        chk("abort_busy", busy, 1);
        step();
        u_if.io_cfg_start = 1'b0;
        u_if.io_cfg_valid = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", u_if.io_cfg_ready, 1);
        chk("abort_mux_kept", mux, {4'h0, cfg_a[99:0]});
        step();
        send_cfg(cfg_b, 1'b0, 13, n);
        chk("abort_n13", n, 13);
        @(negedge clk);
        wait_result(off);
        chk("abort_latency", off, 21);
        chk("abort_done", done, 1);
        chk("abort_mux", mux, {4'h0, cfg_b[99:0]});
        step();

        // Backpressure gaps
        ready_viol = 0;
        do_start();
        send_cfg(cfg_a, 1'b1, 13, n);
        chk("gap_n", n, 13);
        @(negedge clk);
        chk("gap_check_ready", u_if.io_cfg_ready, 0);
        wait_result(off);
        chk("gap_latency", off, 21);
        chk("gap_mux", mux, {4'h0, cfg_a[99:0]});
        chk("gap_ready_viol", ready_viol, 0);
        step();

        // Reset in the middle of the field check
        do_start();
        send_cfg(mk_fill(5), 1'b0, 13, n);
        chk("rstchk_n", n, 13);
        repeat (9) step();
        reset = 1'b0;
        #1;
        chk("rstchk_mux", mux, 0);
        chk("rstchk_busy", busy, 0);
        chk("rstchk_ready", u_if.io_cfg_ready, 0);
        chk("rstchk_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("rstchk_no_done", n_done, 0);
        chk("rstchk_mux_end", mux, 0);
        chk("rstchk_busy_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
